dip_scan_ctrl: RTL and testbench

Parametrised controller for a serial-out DIP/switch shift-register chain (74HC165-style). It generates the chain's load and shift-clock strobes, deserialises N_BITS switch bits into a parallel word, and raises a one-cycle valid strobe per committed frame, with optional change flagging. It sits between the board switch chain and the register/control logic that consumes switch settings. It supersedes the fixed 24-bit free-running reader, adding configurable width, bit order, shift-clock rate, triggered or continuous scanning, and an explicit handshake.

---
 rtl/dip_scan_pkg.sv | 14 +
 rtl/dip_scan_tick.sv | 30 +++
 rtl/dip_scan_ctrl.sv | 107 ++++++++++
 tb/tb_dip_scan_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dip_scan_pkg.sv
// dip_scan_pkg: FSM state type and counter-width helpers shared by the DIP scan controller.
package dip_scan_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

    function automatic int cnt_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

    function automatic int idx_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dip_scan_tick.sv
// dip_scan_tick: CLK_DIV period counter with half-period, high-half and end-of-period strobes.
module dip_scan_tick
    import dip_scan_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic half_o,
    output logic hi_o,
    output logic last_o
);

    localparam int CW = cnt_w(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        half_o = cnt_q == CW'(CLK_DIV / 2 - 1);
        last_o = cnt_q == CW'(CLK_DIV - 1);
        hi_o   = cnt_q >= CW'(CLK_DIV / 2);
        cnt_d  = (clr_i || last_o) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end

endmodule

// File: rtl/dip_scan_ctrl.sv
// dip_scan_ctrl: 74HC165-style switch chain scanner producing one parallel word per frame.
// Define DIP_SCAN_DEBOUNCE_EN to commit only frames equal to the previous raw frame.
module dip_scan_ctrl
    import dip_scan_pkg::*;
#(
    parameter int N_BITS    = 24,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit CONT      = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ser_in,
    output logic              sr_load,
    output logic              sr_clk,
    output logic              busy,
    output logic [N_BITS-1:0] data,
    output logic              data_valid,
    output logic              changed
);

    localparam int BW = idx_w(N_BITS);

    state_e            state_q, state_d;
    logic [BW-1:0]     idx_q, idx_d;
    logic [N_BITS-1:0] sr_q, sr_d, data_q, data_d;
    logic              valid_q, valid_d, chg_q, chg_d;
    logic              half, hi, last, frame_end, commit;

    dip_scan_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == IDLE || state_q == DONE),
        .half_o (half),
        .hi_o   (hi),
        .last_o (last)
    );

    assign frame_end = state_q == SHIFT && last && idx_q == BW'(N_BITS - 1);

`ifdef DIP_SCAN_DEBOUNCE_EN
    logic [N_BITS-1:0] raw_q;
    assign commit = sr_q == raw_q;
    always_ff @(posedge clk) begin
        raw_q <= rst ? '0 : frame_end ? sr_q : raw_q;
    end
`else
    assign commit = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        chg_d   = 1'b0;
        case (state_q)
            IDLE: state_d = (start || CONT) ? LOAD : IDLE;
            LOAD: begin
                state_d = last ? SHIFT : LOAD;
                idx_d   = '0;
            end
            SHIFT: begin
                // capture on the last low cycle, before the rising edge advances the chain
                if (half)
                    sr_d = MSB_FIRST ? N_BITS'({sr_q, ser_in}) : N_BITS'({ser_in, sr_q} >> 1);
                if (last)
                    idx_d = idx_q + 1'b1;
                if (frame_end) begin
                    state_d = DONE;
                    valid_d = commit;
                    chg_d   = commit && sr_q != data_q;
                    data_d  = commit ? sr_q : data_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
        end
    end

    assign sr_load    = state_q != LOAD;
    assign sr_clk     = state_q == SHIFT && hi;
    assign busy       = state_q != IDLE;
    assign data       = data_q;
    assign data_valid = valid_q;
    assign changed    = chg_q;

endmodule

// File: tb/tb_dip_scan_ctrl.sv
// tb_dip_scan_ctrl: self-checking bench for dip_scan_ctrl with behavioural 74HC165 chain models.
module tb_dip_scan_ctrl;

    typedef struct packed {
        logic [7:0] d;
        logic       c;
        logic [7:0] f;
    } exp_t;

    typedef struct {
        logic [7:0] v;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_c = 1'b1;
    logic start = 1'b0;
    logic [7:0] val_ab = 8'h00;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic ld_a, ck_a, busy_a, va, ca, si_a;
    logic ld_b, ck_b, busy_b, vb, cb, si_b;
    logic ld_c, ck_c, busy_c, vc, cc, si_c;
    logic [7:0] d_a, d_b, d_c;
    logic [7:0] ch_a = 8'h00, ch_b = 8'h00, ch_c = 8'h00;
    logic ck_a_q = 1'b0, ck_b_q = 1'b0, ck_c_q = 1'b0, ld_c_q = 1'b1;

    logic [7:0] vals_c[$];
    exp_t qa[$], qb[$], qc[$];
    logic [7:0] prev_m[3];
    logic [7:0] sh_m[3];
    vec_t vecs[6];

    int last_cyc_c = 0;
    logic [7:0] last_f_c = 8'h00;
    logic have_c = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dip_scan_ctrl #(.N_BITS(8), .CLK_DIV(4), .MSB_FIRST(1'b1), .CONT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .ser_in(si_a), .sr_load(ld_a), .sr_clk(ck_a),
        .busy(busy_a), .data(d_a), .data_valid(va), .changed(ca)
    );
    dip_scan_ctrl #(.N_BITS(8), .CLK_DIV(4), .MSB_FIRST(1'b0), .CONT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .ser_in(si_b), .sr_load(ld_b), .sr_clk(ck_b),
        .busy(busy_b), .data(d_b), .data_valid(vb), .changed(cb)
    );
    dip_scan_ctrl #(.N_BITS(8), .CLK_DIV(4), .MSB_FIRST(1'b1), .CONT(1'b1)) dut_c (
        .clk(clk), .rst(rst_c), .start(1'b0), .ser_in(si_c), .sr_load(ld_c), .sr_clk(ck_c),
        .busy(busy_c), .data(d_c), .data_valid(vc), .changed(cc)
    );

    assign si_a = ch_a[7];
    assign si_b = ch_b[7];
    assign si_c = ch_c[7];

    // chain: parallel load while sr_load is low, shift toward QH on each sr_clk rise
    always @(posedge clk) begin
        ck_a_q <= ck_a;
        ck_b_q <= ck_b;
        ck_c_q <= ck_c;
        ld_c_q <= ld_c;
        if (!ld_a) ch_a <= val_ab;
        else if (ck_a && !ck_a_q) ch_a <= ch_a << 1;
        if (!ld_b) ch_b <= val_ab;
        else if (ck_b && !ck_b_q) ch_b <= ch_b << 1;
        if (!ld_c && ld_c_q) ch_c <= (vals_c.size() != 0) ? vals_c.pop_front() : 8'h00;
        else if (ld_c && ck_c && !ck_c_q) ch_c <= ch_c << 1;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic predict(input int i, input logic [7:0] raw, input logic [7:0] f,
                                     output exp_t e);
        logic ok;
`ifdef DIP_SCAN_DEBOUNCE_EN
        ok = raw == sh_m[i];
        sh_m[i] = raw;
`else
        ok = 1'b1;
`endif
        e = '{d: raw, c: raw != prev_m[i], f: f};
        if (ok) prev_m[i] = raw;
        return ok;
    endfunction

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (va) begin
            chk("a_valid_expected", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_data", 64'(d_a), 64'(e.d));
                chk("a_changed", 64'(ca), 64'(e.c));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (vb) begin
            chk("b_valid_expected", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_data", 64'(d_b), 64'(e.d));
                chk("b_changed", 64'(cb), 64'(e.c));
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (vc) begin
            chk("c_valid_expected", 64'(qc.size() != 0), 64'd1);
            if (qc.size() != 0) begin
                e = qc.pop_front();
                chk("c_data", 64'(d_c), 64'(e.d));
                chk("c_changed", 64'(cc), 64'(e.c));
                if (have_c)
                    chk("c_spacing", 64'(cyc - last_cyc_c), 64'(38 * (int'(e.f) - int'(last_f_c))));
                have_c = 1'b1;
                last_cyc_c = cyc;
                last_f_c = e.f;
            end
        end
    end

    task automatic predict_ab(input logic [7:0] ea, input logic [7:0] eb, output logic ok_a);
        exp_t e;
        logic ok;
        ok_a = predict(0, ea, 8'd0, e);
        if (ok_a) qa.push_back(e);
        ok = predict(1, eb, 8'd0, e);
        if (ok) qb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sr_load"}, 64'(ld_a), 64'd1);
        chk({tag, "_sr_clk"}, 64'(ck_a), 64'd0);
        chk({tag, "_busy"}, 64'(busy_a), 64'd0);
        chk({tag, "_data"}, 64'(d_a), 64'd0);
        chk({tag, "_valid"}, 64'(va), 64'd0);
        chk({tag, "_changed"}, 64'(ca), 64'd0);
    endtask

    task automatic scan(input vec_t v);
        logic ok_a;
        int n;
        val_ab = v.v;
        predict_ab(v.ea, v.eb, ok_a);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (busy_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scan_done", 64'(busy_a), 64'd0);
    endtask

    initial begin
        logic ok_a;
        exp_t e;
        logic ok;
        int lo, pulses, nv, nb;
        logic ck_prev;
        vecs[0] = '{v: 8'h5A, ea: 8'h5A, eb: 8'h5A};
        vecs[1] = '{v: 8'h01, ea: 8'h01, eb: 8'h80};
        vecs[2] = '{v: 8'hF0, ea: 8'hF0, eb: 8'h0F};
        vecs[3] = '{v: 8'h80, ea: 8'h80, eb: 8'h01};
        vecs[4] = '{v: 8'h00, ea: 8'h00, eb: 8'h00};
        vecs[5] = '{v: 8'hFF, ea: 8'hFF, eb: 8'hFF};
        for (int i = 0; i < 3; i++) begin
            prev_m[i] = 8'h00;
            sh_m[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // first frame with cycle-accurate strobe checks, start in cycle 0
        val_ab = 8'hA5;
        predict_ab(8'hA5, 8'hA5, ok_a);
        @(negedge clk) start = 1'b1;
        lo = 0;
        pulses = 0;
        ck_prev = 1'b0;
        for (int k = 1; k <= 38; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!ld_a) lo++;
            if (ck_a && !ck_prev) pulses++;
            ck_prev = ck_a;
            if (k == 1) chk("t1_sr_load_low", 64'(ld_a), 64'd0);
            if (k == 5) chk("t5_sr_load_high", 64'(ld_a), 64'd1);
            if (k == 36) chk("t36_valid", 64'(va), 64'd0);
            if (k == 37) begin
                chk("t37_valid", 64'(va), 64'(ok_a));
                chk("t37_busy", 64'(busy_a), 64'd1);
            end
            if (k == 38) chk("t38_busy", 64'(busy_a), 64'd0);
        end
        chk("load_cycles", 64'(lo), 64'd4);
        chk("sr_clk_pulses", 64'(pulses), 64'd8);

        // reset during bit 4 of SHIFT
        val_ab = 8'h3C;
        @(negedge clk) start = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("bit4_busy", 64'(busy_a), 64'd1);
        chk("bit4_sr_clk_low", 64'(ck_a), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prev_m[i] = 8'h00;
            sh_m[i] = 8'h00;
        end
        repeat (45) @(negedge clk);
        chk("post_reset_data", 64'(d_a), 64'd0);

        for (int i = 0; i < 6; i++) begin
            scan(vecs[i]);
            scan(vecs[i]);
        end

        // start held high through a whole frame
        val_ab = 8'hE1;
        predict_ab(8'hE1, 8'h87, ok_a);
        @(negedge clk) start = 1'b1;
        nv = 0;
        nb = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (va) nv++;
            if (k >= 38 && busy_a) nb++;
            if (k == 38) start = 1'b0;
        end
        chk("held_start_frames", 64'(nv), 64'(ok_a));
        chk("held_start_no_requeue", 64'(nb), 64'd0);

        // continuous scanning on the CONT instance
        vals_c = '{8'h3C, 8'h3C, 8'h3C, 8'h11, 8'h22, 8'h22};
        for (int f = 0; f < 6; f++) begin
            ok = predict(2, vals_c[f], 8'(f), e);
            if (ok) qc.push_back(e);
        end
        @(negedge clk) rst_c = 1'b0;
        repeat (230) @(negedge clk);
        rst_c = 1'b1;
        @(negedge clk);
        chk("c_reset_busy", 64'(busy_c), 64'd0);
        chk("c_reset_data", 64'(d_c), 64'd0);

        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);
        chk("qc_drained", 64'(qc.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
